// File: rtl/if_stage_pipe.sv
module if_stage_pipe #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        MEM_DEPTH = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD  = '0,
  parameter logic [INSTR_W-1:0] ROM_INIT [MEM_DEPTH] = '{default: '0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  input  logic               flush,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc4_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {S_RUN, S_HOLD} state_t;

  logic [ADDR_W-1:0]  r_pc;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  w_pc4;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-3:0]  w_word;
  logic [IDX_W-1:0]   w_idx;
  logic               w_in_range;
  logic [INSTR_W-1:0] w_fetch;
  logic               w_do_stall;
  logic               w_do_fetch;

  assign w_pc4      = r_pc + ADDR_W'(4);
  assign w_target   = {branch_target[ADDR_W-1:2], 2'b00};
  assign w_word     = r_pc[ADDR_W-1:2];
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_in_range = ({2'b00, w_word} < ADDR_W'(MEM_DEPTH));
  assign w_fetch    = w_in_range ? ROM_INIT[w_idx] : NOP_WORD;

  assign w_do_stall = !pc_src && !flush && stall;
  assign w_do_fetch = !pc_src && !flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      pc_out    <= '0;
      pc4_out   <= '0;
      instr_out <= NOP_WORD;
      valid_out <= 1'b0;
    end else if (pc_src) begin
      r_pc      <= w_target;
      instr_out <= NOP_WORD;
      valid_out <= 1'b0;
    end else if (flush) begin
      r_pc      <= w_pc4;
      instr_out <= NOP_WORD;
      valid_out <= 1'b0;
    end else if (!stall) begin
      r_pc      <= w_pc4;
      pc_out    <= r_pc;
      pc4_out   <= w_pc4;
      instr_out <= w_fetch;
      valid_out <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_do_stall)  w_state_nxt = S_HOLD;
      S_HOLD:  if (!w_do_stall) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_do_fetch && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if (w_do_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
module tb_if_stage_pipe;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] TB_ROM [64] = '{
      0: 32'h11, 1: 32'h22, 2: 32'h33, 3: 32'h44,
      4: 32'hA4, 5: 32'hA5, default: 32'h0
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_src = 1'b0;
   logic [31:0] branch_target = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] pc_out, pc4_out, instr_out;
   logic        valid_out;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt, stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   if_stage_pipe #(
      .ADDR_W    (32),
      .INSTR_W   (32),
      .MEM_DEPTH (64),
      .RESET_PC  (32'h0),
      .NOP_WORD  (NOP),
      .ROM_INIT  (TB_ROM)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .stall         (stall),
      .flush         (flush),
      .pc_out        (pc_out),
      .pc4_out       (pc4_out),
      .instr_out     (instr_out),
      .valid_out     (valid_out)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_pc, m_pco, m_pc4, m_ins;
   logic        m_v;
   logic [31:0] m_fcnt, m_scnt;

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      logic [31:0] w;
      w = a / 4;
      if (w < 32'd64) return TB_ROM[w[5:0]];
      return NOP;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc <= 32'h0; m_pco <= 32'h0; m_pc4 <= 32'h0; m_ins <= NOP; m_v <= 1'b0;
         m_fcnt <= 32'h0; m_scnt <= 32'h0;
      end else if (pc_src) begin
         m_pc <= (branch_target / 4) * 4;
         m_ins <= NOP; m_v <= 1'b0;
      end else if (flush) begin
         m_pc <= m_pc + 32'd4;
         m_ins <= NOP; m_v <= 1'b0;
      end else if (stall) begin
         if (m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 32'd1;
      end else begin
         m_pco <= m_pc; m_pc4 <= m_pc + 32'd4; m_ins <= fetch_word(m_pc); m_v <= 1'b1;
         m_pc  <= m_pc + 32'd4;
         if (m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 32'd1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         check("model.pc_out",    64'(pc_out),    64'(m_pco));
         check("model.pc4_out",   64'(pc4_out),   64'(m_pc4));
         check("model.instr_out", 64'(instr_out), 64'(m_ins));
         check("model.valid_out", 64'(valid_out), 64'(m_v));
`ifdef IF_PERF_CNT_EN
         check("model.fetch_cnt", 64'(fetch_cnt), 64'(m_fcnt));
         check("model.stall_cnt", 64'(stall_cnt), 64'(m_scnt));
`endif
      end
   end

   // Inputs change 2 time units after a rising edge, well clear of the edges.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic s_src, input logic [31:0] tgt,
                         input logic s_stall, input logic s_flush);
      pc_src = s_src; branch_target = tgt; stall = s_stall; flush = s_flush;
   endtask

   task automatic do_reset();
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk_ifid(input string name, input logic [31:0] e_pc,
                           input logic [31:0] e_pc4, input logic [31:0] e_ins,
                           input logic e_v);
      check({name, ".pc_out"},    64'(pc_out),    64'(e_pc));
      check({name, ".pc4_out"},   64'(pc4_out),   64'(e_pc4));
      check({name, ".instr_out"}, 64'(instr_out), 64'(e_ins));
      check({name, ".valid_out"}, 64'(valid_out), 64'(e_v));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, time %0t expected below 100000", $time);
      $fatal(1);
   end

   initial begin
      // Reset state
      step();
      chk_ifid("reset", 32'h0, 32'h0, NOP, 1'b0);

      // A: plain run
      do_reset();
      step(); chk_ifid("run.e1", 32'h0, 32'h4, 32'h11, 1'b1);
      step();
      step();
      step(); chk_ifid("run.e4", 32'hC, 32'h10, 32'h44, 1'b1);

      // B: branch to 3 at pc=8, low bits masked
      do_reset();
      step(); step();
      set_in(1'b1, 32'h3, 1'b0, 1'b0);
      step(); chk_ifid("br.bubble", 32'h4, 32'h8, NOP, 1'b0);
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_ifid("br.next", 32'h0, 32'h4, 32'h11, 1'b1);

      // C: stall 3 cycles at pc=8
      do_reset();
      step(); step();
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 3; i++) begin
         step(); chk_ifid("stall.hold", 32'h4, 32'h8, 32'h22, 1'b1);
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_ifid("stall.release", 32'h8, 32'hC, 32'h33, 1'b1);

      // D: stall+flush -> bubble, pc 8 -> 12
      do_reset();
      step(); step();
      set_in(1'b0, 32'h0, 1'b1, 1'b1);
      step(); chk_ifid("stflush.bubble", 32'h4, 32'h8, NOP, 1'b0);
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_ifid("stflush.next", 32'hC, 32'h10, 32'h44, 1'b1);

      // E: stall+redirect to 16 -> redirect wins
      set_in(1'b1, 32'h10, 1'b1, 1'b0);
      step(); chk_ifid("stbr.bubble", 32'hC, 32'h10, NOP, 1'b0);
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_ifid("stbr.next", 32'h10, 32'h14, 32'hA4, 1'b1);

      // F: out-of-range fetch, then PC wrap at the top of the address space
      set_in(1'b1, 32'h100, 1'b0, 1'b0);
      step();
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_ifid("oor", 32'h100, 32'h104, NOP, 1'b1);
      set_in(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      step();
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_ifid("wrap.top", 32'hFFFF_FFFC, 32'h0, NOP, 1'b1);
      step(); chk_ifid("wrap.zero", 32'h0, 32'h4, 32'h11, 1'b1);

      // G: async reset mid-stall clears outputs before any edge
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      step(); step();
      #1 rst = 1'b1;
      #1 chk_ifid("async_rst", 32'h0, 32'h0, NOP, 1'b0);
      step();

`ifdef IF_PERF_CNT_EN
      // Counters: 5 run edges + 2 stall edges
      do_reset();
      for (int unsigned i = 0; i < 5; i++) step();
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      step(); step();
      check("perf.fetch_cnt", 64'(fetch_cnt), 64'd5);
      check("perf.stall_cnt", 64'(stall_cnt), 64'd2);
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
